// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle instruction sequencer: states, opcodes and instruction classes.
package mc_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned CLS_W     = 4;
  localparam int unsigned WAIT_W    = 8;
  localparam int unsigned RETIRED_W = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  typedef enum logic [CLS_W-1:0] {
    CLS_NONE   = 4'd0,
    CLS_R      = 4'd1,
    CLS_I_ALU  = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JAL    = 4'd6,
    CLS_JALR   = 4'd7,
    CLS_LUI    = 4'd8,
    CLS_AUIPC  = 4'd9
  } cls_e;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I_ALU  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: maps the 7-bit major opcode to an instruction class.
module opcode_classify
  import mc_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output cls_e                cls,
  output logic                valid
);

  always_comb begin
    cls   = CLS_NONE;
    valid = 1'b1;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I_ALU:  cls = CLS_I_ALU;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute/memory/writeback with memory timeout trap.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 ir_write_enable,
  output logic                 pc_write_enable,
  output logic                 reg_write_enable,
  output logic [STATE_W-1:0]   state,
  output logic                 trap,
  output logic [RETIRED_W-1:0] retired
);

  state_e              state_q, state_d;
  cls_e                cls_q, cls_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  cls_e                dec_cls;
  logic                dec_valid;
  logic                complete;
  logic                timeout;

  opcode_classify u_classify (
    .opcode (opcode),
    .cls    (dec_cls),
    .valid  (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cls_q   <= CLS_NONE;
      wait_q  <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      wait_q  <= wait_d;
      if (complete) begin
        retired <= retired + 32'd1;
      end
    end
  end

  assign state   = state_q;
  assign timeout = (wait_q == WAIT_W'(MAX_WAIT));

  // Wait counter only survives while a request is pending; any other state clears it,
  // so it is zero on every entry to FETCH or MEMORY.
  always_comb begin
    state_d          = state_q;
    cls_d            = cls_q;
    wait_d           = '0;
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    ir_write_enable  = 1'b0;
    pc_write_enable  = 1'b0;
    reg_write_enable = 1'b0;
    trap             = 1'b0;
    complete         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write_enable = 1'b1;
          state_d         = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_DECODE: begin
        cls_d   = dec_cls;
        state_d = dec_valid ? ST_EXECUTE : ST_TRAP;
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
          CLS_BRANCH:          complete = 1'b1;
          default:             state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == CLS_STORE);
        if (mem_ready) begin
          if (cls_q == CLS_STORE) complete = 1'b1;
          else                    state_d  = ST_WRITEBACK;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WRITEBACK: begin
        reg_write_enable = 1'b1;
        complete         = 1'b1;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Every completing state advances the PC and picks the follow-on state from run.
    if (complete) begin
      pc_write_enable = 1'b1;
      state_d         = run ? ST_FETCH : ST_IDLE;
    end
  end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 15: maximum cycles spent waiting for mem_ready in one memory access before trapping; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 run  input  1  permission to start the next instruction.
REQ-005 opcode  input  7  instruction register bits [6:0]; sampled only in DECODE.
REQ-006 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-007 mem_req  output  1  memory access request; held high until mem_ready or timeout.
REQ-008 mem_we  output  1  store qualifier; valid only while mem_req=1.
REQ-009 ir_write_enable  output  1  load instruction register (one-cycle pulse).
REQ-010 pc_write_enable  output  1  advance PC (one-cycle pulse per retired instruction).
REQ-011 reg_write_enable  output  1  register file write (one-cycle pulse).
REQ-012 state  output  3  current state encoding, for debug.
REQ-013 trap  output  1  sticky fault flag.
REQ-014 retired  output  32  count of retired instructions.

Function
REQ-015 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP; state register only, all outputs combinational from state, latched class and mem_ready.
REQ-016 IDLE: all strobes 0; run=1 -> FETCH next cycle, else stay.
REQ-017 FETCH: mem_req=1, mem_we=0; mem_ready=1 -> ir_write_enable=1 the same cycle, next DECODE.
REQ-018 DECODE: classify opcode and latch class: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111; any other value -> TRAP, else EXECUTE.
REQ-019 EXECUTE: one cycle; LOAD/STORE -> MEMORY; BRANCH -> completes here (pc_write_enable=1); all other classes -> WRITEBACK.
REQ-020 MEMORY: mem_req=1, mem_we=1 for STORE, 0 for LOAD; on mem_ready, LOAD -> WRITEBACK, STORE completes in that cycle (pc_write_enable=1).
REQ-021 WRITEBACK: reg_write_enable=1 and pc_write_enable=1 in the same single cycle; instruction completes.
REQ-022 Completion: next state FETCH if run=1, IDLE if run=0; retired increments by 1 in the completion cycle, wrapping 0xFFFFFFFF -> 0.
REQ-023 Cycle counts with zero-wait memory (mem_ready asserted in the first request cycle): BRANCH 3, R/I/LUI/AUIPC/JAL/JALR 4, STORE 4, LOAD 5.
REQ-024 Wait counter 8 bits: cleared on entry to FETCH or MEMORY, increments each request cycle without mem_ready; if it equals MAX_WAIT and mem_ready=0 -> TRAP next cycle, no strobe issued.
REQ-025 mem_ready in the timeout cycle wins: the access completes normally.
REQ-026 mem_ready while mem_req=0 is ignored.
REQ-027 run deasserting mid-instruction does not abort; the instruction finishes, then IDLE.
REQ-028 TRAP: trap=1, all strobes 0, absorbing until reset; retired frozen.

Reset
REQ-029 rst_n=0 at a clock edge: state=IDLE, wait counter=0, latched class=0, retired=0, trap=0; all strobes 0 from that edge, including reset mid-access.
REQ-030 First FETCH occurs no earlier than the cycle after rst_n=1 with run=1.

Structure
REQ-031 Shared package mc_pkg holds the state encoding, the nine opcode constants and the class encoding.
REQ-032 Sub-module opcode_classify (combinational: opcode -> class, valid) is instantiated once.

Verification
REQ-033 Reset, run=1, R-type 0110011, zero-wait -> states FETCH,DECODE,EXECUTE,WRITEBACK; reg_write_enable and pc_write_enable high in cycle 4; retired=1.
REQ-034 LOAD 0000011, mem_ready delayed 3 cycles in MEMORY -> mem_req high 4 cycles with mem_we=0, then WRITEBACK; total 8 cycles.
REQ-035 STORE 0100011 then BRANCH 1100011, zero-wait -> mem_we=1 in MEMORY, no reg_write_enable in either; retired=2 after 7 cycles.
REQ-036 Opcode 1111111 in DECODE -> TRAP next cycle, trap=1 and held; retired unchanged; rst_n=0 returns to IDLE with trap=0.
REQ-037 MAX_WAIT=4, mem_ready never asserted in FETCH -> TRAP after 5 cycles; repeat with mem_ready on cycle 5 -> normal DECODE.
REQ-038 retired preloaded to 0xFFFFFFFF by forcing, one BRANCH retired -> 0; run dropped during EXECUTE -> IDLE after completion.
